rf_writeback_ctrl: RTL
======================

// Module: rf_writeback_ctrl
// PURPOSE
//  Write-side controller for the 32x32 register file write port (write_enable/addr/data).
//  Merges single-cycle ALU results with variable-latency LSU load responses onto one registered write port.
//  Buffers LSU results in a small FIFO and keeps a busy scoreboard of registers awaiting load data.
//  Sits between the execute/LSU stages and the register file; busy_o feeds issue-stall logic.
// PARAMETERS
//  FIFO_DEPTH  4   LSU result buffer entries; power of two, >=2
// PORTS
//  clk_i            in   1   clock, all state on rising edge
//  rst_ni           in   1   asynchronous active-low reset
//  alu_valid_i      in   1   ALU result valid; always accepted, no backpressure
//  alu_rd_i         in   5   ALU destination register
//  alu_data_i       in   32  ALU result
//  lsu_valid_i      in   1   LSU load response valid
//  lsu_ready_o      out  1   LSU response accepted when valid&ready
//  lsu_rd_i         in   5   load destination register
//  lsu_data_i       in   32  load data
//  ld_issue_i       in   1   load issued this cycle; marks ld_issue_rd_i busy
//  ld_issue_rd_i    in   5   destination of issued load
//  rf_we_o          out  1   register file write enable (registered)
//  rf_waddr_o       out  5   register file write address (registered)
//  rf_wdata_o       out  32  register file write data (registered)
//  busy_o           out  32  bit n = load to xn outstanding (in flight or buffered)
// BEHAVIOUR
//  Clock clk_i, reset rst_ni: one clock; reset is asynchronous and active-low.
//  Reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, busy_o=0, FIFO empty, lsu_ready_o=1 one cycle after release.
//  Write port: one write per cycle, output registered; source selected in cycle N, visible on rf_*_o in N+1.
//  Priority: ALU > FIFO head > LSU bypass. ALU is never stalled.
//  Cycle without alu_valid_i: FIFO non-empty -> pop head to port; FIFO empty and LSU handshake -> bypass to port.
//  LSU handshake while ALU owns port or FIFO non-empty -> push to FIFO (preserves load order).
//  lsu_ready_o = !full, computed from registered occupancy only; never depends on lsu_valid_i.
//  Simultaneous push and pop with FIFO full: not allowed (ready=0 blocks push); with FIFO empty: bypass, not push+pop.
//  Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
//  rd==0 from either source: consumes its slot/handshake but rf_we_o stays 0 (x0 never written).
//  Scoreboard: ld_issue_i sets busy[rd]; a load result reaching rf_we_o clears busy[rd] in the same edge.
//  Set and clear of the same register in one cycle: set wins. ld_issue_rd_i==0 never sets a bit.
//  ALU write to a busy register is legal and leaves busy unchanged (issue logic owns WAW ordering).
//  When rf_we_o=0, rf_waddr_o/rf_wdata_o hold previous values.
//  Reset asserted mid-operation: buffered LSU results and busy bits are discarded, no write issued.
// STRUCTURE
//  rv_pkg: XLEN=32, RF_ADDR_W=5, RF_REGS=32, typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_entry_t.
//  Sub-module wb_fifo: parameterised FIFO of wb_entry_t, push/pop/full/empty/count, async active-low reset.
//  Top: source mux, output register, 32-bit scoreboard register.
// TESTING
//  ALU only: alu_valid_i=1, rd=5, data=0xDEADBEEF at cycle 0 -> rf_we_o=1, waddr=5, wdata=0xDEADBEEF at cycle 1.
//  Bypass: idle FIFO, LSU rd=7 data=0x12345678 handshake -> written next cycle, busy_o[7] 1->0 on same edge.
//  Contention: ALU rd=3 and LSU rd=4 same cycle -> x3 written cycle 1, x4 cycle 2; lsu_ready_o stays 1.
//  Fill: ALU valid 6 cycles with LSU valid every cycle, depth 4 -> lsu_ready_o=0 after 4 pushes; drain order rd 10,11,12,13.
//  x0: ALU rd=0 data=0xFFFFFFFF -> rf_we_o stays 0; ld_issue rd=0 -> busy_o stays 0.
//  Scoreboard race: ld_issue rd=9 same cycle as load result rd=9 written -> busy_o[9]=1 afterwards.
//  Reset mid-drain: 3 entries buffered, rst_ni low 1 cycle -> rf_we_o=0, busy_o=0, lsu_ready_o=1, no stale writes.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file types and widths for the writeback path.
package rv_pkg;

  localparam int XLEN      = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_REGS   = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_LSU  = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries used to park LSU results
// while the ALU or older buffered loads own the write port.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  wb_entry_t                push_data_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = mem[rd_ptr];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: the storage array has no reset; validity is tracked solely by
  // count/pointers, so stale contents are never observed after reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port controller: merges ALU results and LSU load
// responses (ALU > buffered load > bypassed load) and tracks pending loads.
module rf_writeback_ctrl
  import rv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_valid_i,
  input  logic [RF_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]      alu_data_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [RF_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]      lsu_data_i,
  input  logic                 ld_issue_i,
  input  logic [RF_ADDR_W-1:0] ld_issue_rd_i,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  output logic [RF_REGS-1:0]   busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t        fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push;
  logic             fifo_pop;
  logic             lsu_hs;
  wb_src_e          sel_src;
  wb_entry_t        sel_entry;
  logic             sel_is_load;
  logic             wr_en;
  logic [RF_REGS-1:0] busy_set;
  logic [RF_REGS-1:0] busy_clr;

  // Ready comes from registered occupancy only, so it never combinationally
  // depends on lsu_valid_i.
  assign lsu_ready_o = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign lsu_hs      = lsu_valid_i && lsu_ready_o;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_data_i ('{rd: lsu_rd_i, data: lsu_data_i}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    sel_src   = SRC_NONE;
    sel_entry = '0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (alu_valid_i) begin
      sel_src   = SRC_ALU;
      sel_entry = '{rd: alu_rd_i, data: alu_data_i};
      fifo_push = lsu_hs;
    end else if (!fifo_empty) begin
      // Older buffered loads drain first; a new response queues behind them.
      sel_src   = SRC_FIFO;
      sel_entry = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = lsu_hs;
    end else if (lsu_hs) begin
      sel_src   = SRC_LSU;
      sel_entry = '{rd: lsu_rd_i, data: lsu_data_i};
    end
  end

  assign sel_is_load = (sel_src == SRC_FIFO) || (sel_src == SRC_LSU);
  // x0 is hardwired: the slot is consumed but nothing is written.
  assign wr_en       = (sel_src != SRC_NONE) && (sel_entry.rd != '0);

  assign busy_set = (ld_issue_i && ld_issue_rd_i != '0)
                    ? (RF_REGS'(1) << ld_issue_rd_i) : '0;
  assign busy_clr = (sel_is_load && wr_en)
                    ? (RF_REGS'(1) << sel_entry.rd) : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      busy_o     <= '0;
    end else begin
      rf_we_o <= wr_en;
      if (wr_en) begin
        rf_waddr_o <= sel_entry.rd;
        rf_wdata_o <= sel_entry.data;
      end
      // Set after clear: a new issue to the same register wins.
      busy_o <= (busy_o & ~busy_clr) | busy_set;
    end
  end

  // Ready must never be high while the buffer is full.
  a_ready_vs_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(fifo_full && lsu_ready_o));

endmodule
